// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter in front of the single-ported data memory.
// Optional DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed A-priority.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic        a_err,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic        b_err,
   output logic [31:0] b_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t      state, state_nx;
   logic        lat_we;
   logic        win;
   logic        err_q;
   logic        any_req;
   logic        grant_b;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        legal;

   assign any_req = a_req | b_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic ptr_b;  // 1: port B wins the next tie

   assign grant_b = b_req & (~a_req | ptr_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_b <= 1'b0;
      else if (state == IDLE && any_req)
         ptr_b <= ~grant_b;
   end
`else
   assign grant_b = b_req & ~a_req;
`endif

   assign sel_we    = grant_b ? b_we    : a_we;
   assign sel_addr  = grant_b ? b_addr  : a_addr;
   assign sel_wdata = grant_b ? b_wdata : a_wdata;
   assign legal     = (sel_addr[1:0] == 2'b00) && ({2'b00, sel_addr[31:2]} < DEPTH_W);

   always_comb begin
      state_nx  = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      a_err     = 1'b0;
      b_err     = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req)
               state_nx = legal ? ACCESS : RESP;
         end
         ACCESS: begin
            mem_read  = ~lat_we;
            mem_write = lat_we;
            state_nx  = RESP;
         end
         RESP: begin
            a_ack    = ~win;
            b_ack    = win;
            a_err    = ~win & err_q;
            b_err    = win & err_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // mem_addr/mem_wdata load only on legal grants so they hold across rejected requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         win       <= 1'b0;
         err_q     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_rdata   <= '0;
         b_rdata   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && any_req) begin
            win    <= grant_b;
            lat_we <= sel_we;
            err_q  <= ~legal;
            if (legal) begin
               mem_addr  <= sel_addr;
               mem_wdata <= sel_wdata;
            end else if (grant_b) begin
               b_rdata <= '0;
            end else begin
               a_rdata <= '0;
            end
         end
         if (state == ACCESS && !lat_we) begin
            if (win)
               b_rdata <= mem_rdata;
            else
               a_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level schedule model plus directed vectors.
module tb_dmem_arbiter;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy;

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory behind the arbiter: combinational read, write on the rising edge
   logic [31:0] ram [0:DEPTH-1];
   assign mem_rdata = ram[mem_addr[6:2]];
   always @(posedge clk) if (mem_write) ram[mem_addr[6:2]] <= mem_wdata;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each grant schedules what every later period must show
   typedef struct packed {
      logic        strobe, we;
      logic [31:0] addr, wdata;
      logic        ack, port, err, upd;
      logic [31:0] rdata;
   } rec_t;

   rec_t        sched [int];
   rec_t        now = '0;
   logic [31:0] shadow [0:DEPTH-1];
   int          cyc = 0;
   int          next_free = 0;
   bit          last_b = 1'b1;
   logic [31:0] cur_addr = '0, cur_wdata = '0;
   logic [31:0] cur_rd [0:1] = '{32'h0, 32'h0};
   bit          busy_exp = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sched.delete();
         now = '0;
         next_free = 0;
         last_b = 1'b1;
         cur_addr = '0;
         cur_wdata = '0;
         cur_rd[0] = '0;
         cur_rd[1] = '0;
         busy_exp = 1'b0;
      end else begin
         if (sched.exists(cyc)) begin
            if (sched[cyc].strobe && sched[cyc].we)
               shadow[sched[cyc].addr[6:2]] = sched[cyc].wdata;
            sched.delete(cyc);
         end
         cyc++;
         if (cyc >= next_free && (a_req || b_req)) begin
            bit          p;
            bit          we;
            logic [31:0] ad, wd;
            rec_t        r;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            p = (a_req && b_req) ? ~last_b : ~a_req;
`else
            p = ~a_req;
`endif
            last_b = p;
            we = p ? b_we : a_we;
            ad = p ? b_addr : a_addr;
            wd = p ? b_wdata : a_wdata;
            if (ad % 4 == 0 && ad / 4 < DEPTH) begin
               r = '0; r.strobe = 1'b1; r.we = we; r.addr = ad; r.wdata = wd;
               sched[cyc] = r;
               r = '0; r.ack = 1'b1; r.port = p; r.upd = ~we;
               r.rdata = we ? 32'h0 : shadow[ad / 4];
               sched[cyc + 1] = r;
               next_free = cyc + 3;
            end else begin
               r = '0; r.ack = 1'b1; r.port = p; r.err = 1'b1; r.upd = 1'b1;
               sched[cyc] = r;
               next_free = cyc + 2;
            end
         end
         now = sched.exists(cyc) ? sched[cyc] : '0;
         if (now.strobe) begin
            cur_addr = now.addr;
            cur_wdata = now.wdata;
         end
         if (now.ack && now.upd) cur_rd[now.port] = now.rdata;
         busy_exp = cyc < next_free - 1;
      end
   end

   int strobes = 0;
   int backs = 0;

   always @(negedge clk) begin
      chk("mem_read",  32'(mem_read),  32'(now.strobe & ~now.we));
      chk("mem_write", 32'(mem_write), 32'(now.strobe & now.we));
      chk("mem_addr",  mem_addr,  cur_addr);
      chk("mem_wdata", mem_wdata, cur_wdata);
      chk("a_ack", 32'(a_ack), 32'(now.ack & ~now.port));
      chk("a_err", 32'(a_err), 32'(now.ack & ~now.port & now.err));
      chk("b_ack", 32'(b_ack), 32'(now.ack & now.port));
      chk("b_err", 32'(b_err), 32'(now.ack & now.port & now.err));
      chk("a_rdata", a_rdata, cur_rd[0]);
      chk("b_rdata", b_rdata, cur_rd[1]);
      chk("busy", 32'(busy), 32'(busy_exp));
      strobes += int'(mem_read | mem_write);
      backs += int'(b_ack);
   end

   task automatic txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err);
      bit got = 1'b0;
      rd = 'x;
      err = 'x;
      @(negedge clk);
      if (p) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
      else   begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (p ? b_ack : a_ack) begin
            got = 1'b1;
            rd  = p ? b_rdata : a_rdata;
            err = p ? b_err : a_err;
         end else if (p) begin
            b_addr = $urandom; b_wdata = $urandom;
         end else begin
            a_addr = $urandom; a_wdata = $urandom;
         end
      end
      if (p) b_req = 1'b0; else a_req = 1'b0;
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          s0, s1, s2, acks, n;
      bit          seq [4];
      bit          exp_seq [4];

      for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; shadow[i] = '0; end
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      #2 rst_n = 1'b1;

      txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err);
      chk("a_write_err", 32'(err), 32'd0);
      txn(1'b0, 1'b0, 32'h10, 32'h0, rd, err);
      chk("a_read_data", rd, 32'hDEADBEEF);

      s0 = strobes;
      txn(1'b1, 1'b0, 32'h6, 32'h0, rd, err);
      chk("b_misaligned_err", 32'(err), 32'd1);
      chk("b_misaligned_rdata", rd, 32'h0);
      txn(1'b1, 1'b0, 32'h80, 32'h0, rd, err);
      chk("b_range_err", 32'(err), 32'd1);
      chk("b_range_rdata", rd, 32'h0);
      txn(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1, rd, err);
      chk("a_high_addr_err", 32'(err), 32'd1);
      chk("no_strobe_on_error", 32'(strobes - s0), 32'd0);

      txn(1'b1, 1'b1, 32'h7C, 32'hCAFE_0001, rd, err);
      chk("b_last_word_err", 32'(err), 32'd0);
      txn(1'b0, 1'b0, 32'h7C, 32'h0, rd, err);
      chk("a_last_word_data", rd, 32'hCAFE_0001);

      // back-to-back A reads with a_req held through the ack
      @(negedge clk);
      a_we = 1'b0; a_addr = 32'h10; a_req = 1'b1;
      s1 = -1; s2 = -1; acks = 0;
      for (int i = 0; i < 20 && acks < 2; i++) begin
         @(negedge clk);
         if (mem_read) begin if (s1 < 0) s1 = i; else s2 = i; end
         if (a_ack) acks++;
      end
      a_req = 1'b0;
      chk("b2b_acks", 32'(acks), 32'd2);
      chk("b2b_strobe_gap", 32'(s2 - s1), 32'd3);

      // last grant went to B so the tie sequence starts from A in both modes
      txn(1'b1, 1'b0, 32'h7C, 32'h0, rd, err);
      chk("b_read_last_word", rd, 32'hCAFE_0001);
      @(negedge clk);
      a_we = 1'b0; a_addr = 32'h10; b_we = 1'b0; b_addr = 32'h7C;
      a_req = 1'b1; b_req = 1'b1;
      n = 0;
      for (int i = 0; i < 30 && n < 4; i++) begin
         @(negedge clk);
         if (a_ack) begin seq[n] = 1'b0; n++; end
         else if (b_ack) begin seq[n] = 1'b1; n++; end
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("tie_grants", 32'(n), 32'd4);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

      // reset during the ACCESS cycle of a B write
      repeat (2) @(negedge clk);
      b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h1234_5678; b_req = 1'b1;
      n = 0;
      for (int i = 0; i < 5 && n == 0; i++) begin
         @(negedge clk);
         if (mem_write) n = 1;
      end
      chk("rst_test_strobe_seen", 32'(n), 32'd1);
      s0 = backs;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_strobe_drop", 32'(mem_write), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      b_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_b_ack", 32'(backs - s0), 32'd0);
      #2 rst_n = 1'b1;
      txn(1'b1, 1'b1, 32'h20, 32'h1234_5678, rd, err);
      chk("reissue_err", 32'(err), 32'd0);
      txn(1'b1, 1'b0, 32'h20, 32'h0, rd, err);
      chk("reissue_read", rd, 32'h1234_5678);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
